// File: rtl/i2c_inject.sv
// i2c_inject: single-clock 3-byte I2C write initiator (addr+W, register, data) on open-drain enables
// Ports: clk; reset (async, active low); start/dev_addr/reg_addr/wr_data request a write;
// scl_in/sda_in raw bus pins; scl_oe/sda_oe pull-low enables; busy, done (1-cycle pulse), nack (sticky).
// Optional: define I2C_STRETCH_EN to honour target clock stretching in BIT/ACK phases.
module i2c_inject #(
  parameter int CLK_DIV = 125
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wr_data,
  input  logic       scl_in,
  input  logic       sda_in,
  output logic       scl_oe,
  output logic       sda_oe,
  output logic       busy,
  output logic       done,
  output logic       nack
);
  typedef enum logic [2:0] {IDLE, START, BIT, ACK, STOP, DONE} state_t;
  localparam int QW = $clog2(CLK_DIV);
  localparam logic [QW-1:0] QMAX = QW'(CLK_DIV - 1);
  state_t state, ns;
  logic [QW-1:0] q;
  logic [1:0] qi, nqi, byte_i, nbyte;
  logic [2:0] bit_i, nbit;
  logic [23:0] sh, nsh;
  logic [1:0] sda_s;
  logic hold, tick;
`ifdef I2C_STRETCH_EN
  logic [1:0] scl_s;
  always_ff @(posedge clk or negedge reset)
    if (!reset) scl_s <= '0;
    else scl_s <= {scl_s[0], scl_in};
  // a target holding SCL low freezes the end of the released-clock quarter
  assign hold = (state == BIT || state == ACK) && qi == 2'd2 && !scl_s[1];
`else
  logic unused_scl;
  assign unused_scl = scl_in;
  assign hold = 1'b0;
`endif
  assign tick = q == QMAX && !hold;
  // next-state view; outputs are registered from it so they line up with the quarter they describe
  always_comb begin
    ns = state;
    nqi = qi;
    nbit = bit_i;
    nbyte = byte_i;
    nsh = sh;
    if (state == IDLE) begin
      if (start) begin
        ns = START;
        nqi = 2'd0;
        nbit = 3'd7;
        nbyte = 2'd0;
        nsh = {dev_addr, 1'b0, reg_addr, wr_data};
      end
    end else if (state == DONE) begin
      ns = IDLE;
    end else if (tick) begin
      nqi = qi + 2'd1;
      if (qi == 2'd3) begin
        ns = state == START ? BIT :
             state == BIT   ? (bit_i == 3'd0 ? ACK : BIT) :
             state == ACK   ? ((nack || byte_i == 2'd2) ? STOP : BIT) : DONE;
        // bit index wraps 0->7 by itself, so it is already 7 for the next byte
        nbit = state == BIT ? bit_i - 3'd1 : bit_i;
        nbyte = state == ACK ? byte_i + 2'd1 : byte_i;
        nsh = state == BIT ? {sh[22:0], 1'b0} : sh;
      end
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      q <= '0;
      qi <= 2'd0;
      bit_i <= 3'd0;
      byte_i <= 2'd0;
      sh <= '0;
      sda_s <= 2'd0;
      scl_oe <= 1'b0;
      sda_oe <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      nack <= 1'b0;
    end else begin
      sda_s <= {sda_s[0], sda_in};
      state <= ns;
      qi <= nqi;
      bit_i <= nbit;
      byte_i <= nbyte;
      sh <= nsh;
      q <= (state == IDLE || state == DONE || tick) ? '0 : q == QMAX ? q : q + 1'b1;
      scl_oe <= (ns == START && nqi == 2'd3) || ((ns == BIT || ns == ACK || ns == STOP) && !nqi[1]);
      sda_oe <= (ns == START && nqi[1]) || (ns == BIT && !nsh[23]) || (ns == STOP && nqi != 2'd3);
      busy <= ns != IDLE;
      done <= ns == DONE;
      if (state == IDLE && start) nack <= 1'b0;
      else if (state == ACK && qi == 2'd2 && tick && sda_s[1]) nack <= 1'b1;
    end
  end
endmodule

// File: tb/tb_i2c_inject.sv
// tb_i2c_inject: randomized self-checking bench for i2c_inject with a byte-level I2C target model
module tb_i2c_inject;
  localparam int CD = 4;
  logic clk = 0, reset = 0, start = 0;
  logic [6:0] dev_addr = 0;
  logic [7:0] reg_addr = 0, wr_data = 0;
  logic scl_in, sda_in, scl_oe, sda_oe, busy, done, nack;
  int errors = 0, checks = 0;
  int nack_byte = 3;
  logic stretch_on = 0;
  logic [7:0] rx [3];
  int pc = 0, rc = 0, hold_cnt = 0, stops = 0;
  logic pull = 0, hold = 0, scl_p = 0, sda_p = 0;

  i2c_inject #(.CLK_DIV(CD)) dut (
    .clk(clk), .reset(reset), .start(start), .dev_addr(dev_addr), .reg_addr(reg_addr),
    .wr_data(wr_data), .scl_in(scl_in), .sda_in(sda_in), .scl_oe(scl_oe), .sda_oe(sda_oe),
    .busy(busy), .done(done), .nack(nack)
  );

  always #5 clk = ~clk;
  assign scl_in = !(scl_oe || hold);
  assign sda_in = !(sda_oe || pull);

  // target model: counts master SCL pulls/releases since the last START condition,
  // shifts in data bits on SCL release, drives ACK in the 9th clock of each byte
  always @(negedge clk) begin
    if (hold_cnt > 0) hold_cnt--;
    if (sda_oe && !sda_p && !scl_oe && !scl_p) begin
      pc = 0; rc = 0; stops = 0;
      rx[0] = 0; rx[1] = 0; rx[2] = 0;
    end else begin
      if (scl_oe && !scl_p) pc++;
      if (!scl_oe && scl_p) begin
        if (rc < 27 && rc % 9 != 8) rx[rc / 9] = {rx[rc / 9][6:0], !sda_oe};
        if (stretch_on && rc == 13) hold_cnt = 20;
        rc++;
      end
      if (!sda_oe && sda_p && !scl_oe && !scl_p) stops++;
    end
    pull = pc > 0 && pc % 9 == 0 && (pc / 9 - 1) != nack_byte;
    hold = hold_cnt > 0;
    scl_p = scl_oe;
    sda_p = sda_oe;
  end

  function automatic int exp_done(input int nk);
    return (nk > 2 ? 116 : 8 + 36 * (nk + 1)) * CD + 1;
  endfunction

  task automatic xfer(input logic [6:0] d, input logic [7:0] r, input logic [7:0] w, input int pulse_at,
                      output int dcyc, output logic b1, output logic n1, output logic bafter);
    @(negedge clk);
    dev_addr = d; reg_addr = r; wr_data = w; start = 1;
    dcyc = -1; b1 = 0; n1 = 1;
    for (int n = 1; n <= 3000; n++) begin
      @(posedge clk); #1;
      start = (n == pulse_at);
      if (n == pulse_at) {dev_addr, reg_addr, wr_data} = 23'($urandom);
      if (n == 1) begin b1 = busy; n1 = nack; end
      if (done) begin dcyc = n; break; end
    end
    @(posedge clk); #1;
    start = 0;
    bafter = busy;
  endtask

  task automatic test_reset();
    reset = 0;
    repeat (3) @(negedge clk);
    checks++;
    if ({scl_oe, sda_oe, busy, done, nack} !== 5'b0) begin
      errors++; $display("FAIL reset_outputs: got %b want 00000", {scl_oe, sda_oe, busy, done, nack});
    end
    reset = 1;
    @(negedge clk);
  endtask

  task automatic test_ack_all();
    int d; logic b1, n1, ba;
    nack_byte = 3;
    xfer(7'h4A, 8'h21, 8'h5C, -1, d, b1, n1, ba);
    checks++; if (d != 465) begin errors++; $display("FAIL ack_all_done: got %0d want 465", d); end
    checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL ack_all_busy1: got %b want 1", b1); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL ack_all_busy_after: got %b want 0", ba); end
    checks++; if (nack !== 1'b0) begin errors++; $display("FAIL ack_all_nack: got %b want 0", nack); end
    checks++; if (rx[0] !== 8'h94) begin errors++; $display("FAIL ack_all_b0: got %h want 94", rx[0]); end
    checks++; if (rx[1] !== 8'h21) begin errors++; $display("FAIL ack_all_b1: got %h want 21", rx[1]); end
    checks++; if (rx[2] !== 8'h5C) begin errors++; $display("FAIL ack_all_b2: got %h want 5c", rx[2]); end
    checks++; if (stops != 1) begin errors++; $display("FAIL ack_all_stop: got %0d want 1", stops); end
    checks++; if ({scl_oe, sda_oe} !== 2'b00) begin errors++; $display("FAIL ack_all_release: got %b want 00", {scl_oe, sda_oe}); end
  endtask

  task automatic test_nack_addr();
    int d; logic b1, n1, ba;
    nack_byte = 0;
    xfer(7'h4A, 8'h21, 8'h5C, -1, d, b1, n1, ba);
    checks++; if (d != 177) begin errors++; $display("FAIL nack_addr_done: got %0d want 177", d); end
    checks++; if (nack !== 1'b1) begin errors++; $display("FAIL nack_addr_flag: got %b want 1", nack); end
    checks++; if (rx[0] !== 8'h94) begin errors++; $display("FAIL nack_addr_b0: got %h want 94", rx[0]); end
    checks++; if (stops != 1) begin errors++; $display("FAIL nack_addr_stop: got %0d want 1", stops); end
    repeat (10) @(negedge clk);
    checks++; if (nack !== 1'b1) begin errors++; $display("FAIL nack_addr_held: got %b want 1", nack); end
    nack_byte = 3;
  endtask

  task automatic test_start_ignored();
    int d; logic b1, n1, ba;
    nack_byte = 3;
    xfer(7'h4A, 8'h21, 8'h5C, 100, d, b1, n1, ba);
    checks++; if (n1 !== 1'b0) begin errors++; $display("FAIL accept_clears_nack: got %b want 0", n1); end
    checks++; if (d != 465) begin errors++; $display("FAIL ignored_done: got %0d want 465", d); end
    checks++; if ({rx[0], rx[1], rx[2]} !== 24'h94215C) begin
      errors++; $display("FAIL ignored_bytes: got %h want 94215c", {rx[0], rx[1], rx[2]});
    end
  endtask

  task automatic test_done_start();
    int d; logic b1, n1, ba;
    nack_byte = 3;
    xfer(7'($urandom), 8'($urandom), 8'($urandom), exp_done(3), d, b1, n1, ba);
    checks++; if (d != exp_done(3)) begin errors++; $display("FAIL done_start_done: got %0d want %0d", d, exp_done(3)); end
    checks++; if (ba !== 1'b0) begin errors++; $display("FAIL done_start_ignored: busy got %b want 0", ba); end
  endtask

  task automatic test_back_to_back();
    int d; logic b1, n1, ba;
    logic [6:0] da; logic [7:0] ra, wa;
    nack_byte = 3;
    for (int i = 0; i < 2; i++) begin
      da = 7'($urandom); ra = 8'($urandom); wa = 8'($urandom);
      xfer(da, ra, wa, -1, d, b1, n1, ba);
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL b2b_accept[%0d]: busy got %b want 1", i, b1); end
      checks++; if (d != 465) begin errors++; $display("FAIL b2b_done[%0d]: got %0d want 465", i, d); end
      checks++; if ({rx[0], rx[1], rx[2]} !== {da, 1'b0, ra, wa}) begin
        errors++; $display("FAIL b2b_bytes[%0d]: got %h want %h", i, {rx[0], rx[1], rx[2]}, {da, 1'b0, ra, wa});
      end
    end
  endtask

  task automatic test_reset_mid();
    int d; logic b1, n1, ba;
    nack_byte = 3;
    @(negedge clk);
    dev_addr = 7'h4A; reg_addr = 8'h21; wr_data = 8'h5C; start = 1;
    for (int n = 1; n < 200; n++) begin
      @(posedge clk); #1;
      start = 0;
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL reset_mid_busy_before: got %b want 1", busy); end
    @(posedge clk); #1;
    reset = 0;
    #1;
    checks++; if ({scl_oe, sda_oe, busy, nack} !== 4'b0) begin
      errors++; $display("FAIL reset_mid_clear: got %b want 0000", {scl_oe, sda_oe, busy, nack});
    end
    repeat (3) @(negedge clk);
    reset = 1;
    checks++; if (stops != 0) begin errors++; $display("FAIL reset_mid_no_stop: got %0d want 0", stops); end
    xfer(7'h4A, 8'h21, 8'h5C, -1, d, b1, n1, ba);
    checks++; if (d != 465) begin errors++; $display("FAIL reset_mid_rerun: got %0d want 465", d); end
    checks++; if ({rx[0], rx[1], rx[2]} !== 24'h94215C) begin
      errors++; $display("FAIL reset_mid_bytes: got %h want 94215c", {rx[0], rx[1], rx[2]});
    end
  endtask

  task automatic test_random();
    int d; logic b1, n1, ba;
    logic [6:0] da; logic [7:0] ra, wa;
    logic [7:0] exp_b [3];
    for (int i = 0; i < 6; i++) begin
      da = 7'($urandom); ra = 8'($urandom); wa = 8'($urandom);
      nack_byte = $urandom_range(0, 3);
      exp_b[0] = {da, 1'b0}; exp_b[1] = ra; exp_b[2] = wa;
      xfer(da, ra, wa, -1, d, b1, n1, ba);
      checks++; if (d != exp_done(nack_byte)) begin
        errors++; $display("FAIL rand_done[%0d]: got %0d want %0d", i, d, exp_done(nack_byte));
      end
      checks++; if (nack !== (nack_byte < 3)) begin
        errors++; $display("FAIL rand_nack[%0d]: got %b want %b", i, nack, nack_byte < 3);
      end
      for (int k = 0; k < 3; k++)
        if (k <= nack_byte) begin
          checks++; if (rx[k] !== exp_b[k]) begin
            errors++; $display("FAIL rand_byte[%0d][%0d]: got %h want %h", i, k, rx[k], exp_b[k]);
          end
        end
    end
    nack_byte = 3;
  endtask

  task automatic test_stretch();
    int d, want; logic b1, n1, ba;
`ifdef I2C_STRETCH_EN
    want = exp_done(3) + 19;
`else
    want = exp_done(3);
`endif
    nack_byte = 3;
    stretch_on = 1;
    xfer(7'h4A, 8'h21, 8'h5C, -1, d, b1, n1, ba);
    stretch_on = 0;
    checks++; if (d != want) begin errors++; $display("FAIL stretch_done: got %0d want %0d", d, want); end
    checks++; if (nack !== 1'b0) begin errors++; $display("FAIL stretch_nack: got %b want 0", nack); end
    checks++; if ({rx[0], rx[1], rx[2]} !== 24'h94215C) begin
      errors++; $display("FAIL stretch_bytes: got %h want 94215c", {rx[0], rx[1], rx[2]});
    end
  endtask

  initial begin
    test_reset();
    test_ack_all();
    test_nack_addr();
    test_start_ignored();
    test_done_start();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_stretch();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/i2c_inject.md
# i2c_inject

Single-clock I2C write initiator for the glitch rig. On a `start` pulse it drives a complete 3-byte write onto the bus through open-drain enables: device address+W, register address, data byte. It lets the rig force PMIC register writes on the same bus that the sniffers listen to. It is the transmit-side counterpart of the bus listener and reports completion and any NACK to the controlling logic.

## Interface
Parameters:
- `CLK_DIV`, default 125: `clk` cycles per SCL quarter-period. The default gives 100 kHz SCL from 50 MHz. The legal minimum is 3.

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `start`  in  1  one-cycle request; ignored while `busy`.
- `dev_addr`  in  7  7-bit target address; latched on accept.
- `reg_addr`  in  8  register byte; latched on accept.
- `wr_data`  in  8  data byte; latched on accept.
- `scl_in`  in  1  raw SCL pin state.
- `sda_in`  in  1  raw SDA pin state.
- `scl_oe`  out  1  1 = pull SCL low; 0 = release.
- `sda_oe`  out  1  1 = pull SDA low; 0 = release.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle pulse at the end of the transfer.
- `nack`  out  1  a NACK was seen in the last transfer; held until the next accept.

## Operation
- `scl_in` and `sda_in` each pass through a 2-flop synchronizer. All sampling uses the synchronized values.
- Quarter counter `q`:
  - counts 0..CLK_DIV-1 and emits `tick` at CLK_DIV-1;
  - is held at 0 in IDLE;
  - 4 quarters (Q0..Q3) make one phase.
- States: IDLE, START, BIT, ACK, STOP, DONE.
- IDLE:
  - all outputs 0.
  - If `start`=1: latch the three bytes as b0={dev_addr,1'b0}, b1=reg_addr, b2=wr_data; clear `nack`; set `busy`; go to START.
- START:
  - Q0–Q1: both lines released.
  - Q2: `sda_oe`=1.
  - Q3: `sda_oe`=1, `scl_oe`=1.
  - Then go to BIT with byte=0, bit=7.
- BIT (MSB first):
  - Q0–Q1: `scl_oe`=1, `sda_oe`=~bit.
  - Q2–Q3: `scl_oe`=0, `sda_oe` unchanged.
  - After bit 0, go to ACK.
- ACK:
  - `sda_oe`=0 throughout.
  - `scl_oe`=1 in Q0–Q1, 0 in Q2–Q3.
  - Synced SDA is sampled on the Q2 tick; a sample of 1 sets `nack`.
  - On ACK with byte<2: next byte, BIT.
  - On ACK with byte=2, or on any NACK: go to STOP. The remaining bytes are skipped.
- STOP:
  - Q0–Q1: `scl_oe`=1, `sda_oe`=1.
  - Q2: `scl_oe`=0, `sda_oe`=1.
  - Q3: both released.
- DONE: `done`=1 for one cycle, `busy` falls, go to IDLE.
- Reset asserted at any time, including mid-byte: all state, the counter and all outputs clear immediately. The bus is released with no STOP.

## Timing
- Cycle 0: `start` sampled. Cycle 1: `busy`=1 and the START phase begins.
- Full ACKed transfer is 116 quarters (4 + 27×4 + 4). `done` is high in cycle 116·CLK_DIV+1; `busy` is 0 from cycle 116·CLK_DIV+2.
- NACK on byte k (0..2) gives 4+36(k+1)+4 quarters.
- `start` on the same cycle as `done` is ignored. The earliest re-accept is the cycle after `done`.
- Outputs are registered; an `scl_oe`/`sda_oe` change occurs in the cycle after the tick that ends the previous quarter.

## Configuration
- `I2C_STRETCH_EN` defined: in BIT and ACK phases, the Q2 tick is withheld while synced `scl_in`=0. `q` holds at CLK_DIV-1 until synced `scl_in`=1.
- Not defined: `scl_in` is unused and timing is fixed as above.

## Test plan
- CLK_DIV=4, dev 0x4A, reg 0x21, data 0x5C, responder ACKs all bytes -> SDA bytes 0x94, 0x21, 0x5C; `done` at cycle 465; `nack`=0.
- Same stimulus, responder NACKs the address -> STOP immediately after the first ACK slot; `done` at cycle 177; `nack`=1 until the next accept.
- `start` pulsed again at cycle 100 of a transfer -> ignored; latched bytes are unchanged; `done` still at cycle 465.
- `reset` low at cycle 200 -> `scl_oe`=`sda_oe`=`busy`=`nack`=0 in the same cycle. A new `start` after release runs a full 465-cycle transfer.
- `I2C_STRETCH_EN`: responder holds `scl_in` low for 20 cycles from the start of Q2 of byte 1, bit 3 -> `done` occurs 19 cycles later than in the first scenario.
- Without the macro, the same stretch stimulus -> `done` at cycle 465.
